// File: rtl/instr_mem_loader_pkg.sv
// Shared processor package: loader FSM encoding, instruction opcodes and the end-of-program word.
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE,
        ERROR
    } ld_state_t;

    // Primary opcodes occupy instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h0a;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_HLT   = 6'h3f;

    localparam logic [31:0] HLT_WORD_DEF = {OP_HLT, 26'd0};

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Big-endian byte-to-word shift buffer; word_valid flags the cycle its 4th byte is accepted.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            word <= '0;
        end else if (clr) begin
            cnt  <= '0;
            word <= '0;
        end else if (shift_en) begin
            cnt  <= cnt + 2'd1;
            word <= {word[23:0], data};
        end
    end

    assign word_valid = shift_en && (cnt == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Streams big-endian program bytes into instruction memory until the halt word, then releases the processor.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] HLT_WORD = HLT_WORD_DEF
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              load_done,
    output logic              proc_start,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    ld_state_t         state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_hold;
    logic [31:0]       pk_word, wdata_hold;
    logic [ADDR_W:0]   wcount;
    logic              proc_q, accept, word_valid, session_go, is_hlt;

    assign s_ready    = (state == COLLECT);
    assign accept     = s_valid && s_ready;
    assign session_go = ld_start && (state == IDLE || state == DONE || state == ERROR);
    assign is_hlt     = (pk_word == HLT_WORD);

    byte_packer u_packer (
        .clk        (clk1),
        .rst_n      (rst_n),
        .clr        (session_go),
        .shift_en   (accept),
        .data       (s_data),
        .word       (pk_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERROR: if (ld_start) state_nxt = COLLECT;
            COLLECT:           if (word_valid) state_nxt = WRITE;
            WRITE: begin
                if (is_hlt)                  state_nxt = DONE;
                else if (addr == LAST_ADDR)  state_nxt = ERROR;
                else                         state_nxt = COLLECT;
            end
            default:           state_nxt = IDLE;
        endcase
    end

    // Address only advances when another word can still fit
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            wcount     <= '0;
            proc_q     <= 1'b0;
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            proc_q <= (state == WRITE) && is_hlt;
            if (session_go) begin
                addr   <= '0;
                wcount <= '0;
            end else if (state == WRITE) begin
                wcount     <= wcount + 1'b1;
                addr_hold  <= addr;
                wdata_hold <= pk_word;
                if (!is_hlt && addr != LAST_ADDR) addr <= addr + 1'b1;
            end
        end
    end

    assign mem_we     = (state == WRITE);
    assign mem_addr   = mem_we ? addr : addr_hold;
    assign mem_wdata  = mem_we ? pk_word : wdata_hold;
    assign load_done  = (state == DONE);
    assign load_err   = (state == ERROR);
    assign proc_start = proc_q;
    assign word_count = wcount;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: a byte-queue model predicts every output each cycle.
module tb_instr_mem_loader;

    localparam logic [31:0] HLT = 32'hfc000000;
    localparam logic [31:0] PROG [4] = '{32'h2801000a, 32'h28020014, 32'h00222000, 32'hfc000000};

    logic clk, rst_n, sel, ld_start, s_valid;
    logic [7:0] s_data;

    logic        a_ready, a_we, a_done, a_proc, a_err;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata;
    logic [10:0] a_wc;
    logic        b_ready, b_we, b_done, b_proc, b_err;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_wc;

    instr_mem_loader #(.ADDR_W(10)) dut_a (
        .clk1(clk), .rst_n(rst_n), .ld_start(ld_start & ~sel), .s_valid(s_valid & ~sel),
        .s_ready(a_ready), .s_data(s_data), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .load_done(a_done), .proc_start(a_proc), .load_err(a_err),
        .word_count(a_wc)
    );

    instr_mem_loader #(.ADDR_W(2)) dut_b (
        .clk1(clk), .rst_n(rst_n), .ld_start(ld_start & sel), .s_valid(s_valid & sel),
        .s_ready(b_ready), .s_data(s_data), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .load_done(b_done), .proc_start(b_proc), .load_err(b_err),
        .word_count(b_wc)
    );

    logic        s_ready, mem_we, load_done, proc_start, load_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [10:0] word_count;

    assign s_ready    = sel ? b_ready : a_ready;
    assign mem_we     = sel ? b_we    : a_we;
    assign mem_addr   = sel ? {8'd0, b_addr} : a_addr;
    assign mem_wdata  = sel ? b_wdata : a_wdata;
    assign load_done  = sel ? b_done  : a_done;
    assign proc_start = sel ? b_proc  : a_proc;
    assign load_err   = sel ? b_err   : a_err;
    assign word_count = sel ? {8'd0, b_wc} : a_wc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests, fails;
    // Model state: accepted bytes of this session, words written, halt seen
    logic [7:0]  mq[$];
    int          nwr, last_addr, proc_cnt;
    bit          active, hlt, proc_now;
    logic [31:0] last_data;
    int          log_addr[$];
    logic [31:0] log_data[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        int depth;
        bit writing, ended_err, exp_ready, proc_next;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0; hlt = 0; nwr = 0; mq.delete();
                last_addr = 0; last_data = 0; proc_now = 0;
            end
            depth     = sel ? 4 : 1024;
            writing   = active && !hlt && (mq.size() == 4 * nwr + 4);
            w         = writing ? {mq[4*nwr], mq[4*nwr+1], mq[4*nwr+2], mq[4*nwr+3]} : 32'h0;
            ended_err = active && !hlt && (nwr == depth);
            exp_ready = active && !writing && !hlt && !ended_err;
            if (writing) begin
                last_addr = nwr;
                last_data = w;
            end
            check("s_ready", 64'(s_ready), 64'(exp_ready));
            check("mem_we", 64'(mem_we), 64'(writing));
            check("mem_addr", 64'(mem_addr), 64'(last_addr));
            check("mem_wdata", 64'(mem_wdata), 64'(last_data));
            check("load_done", 64'(load_done), 64'(hlt));
            check("load_err", 64'(load_err), 64'(ended_err));
            check("proc_start", 64'(proc_start), 64'(proc_now));
            check("word_count", 64'(word_count), 64'(nwr));
            if (mem_we) begin
                log_addr.push_back(int'(mem_addr));
                log_data.push_back(mem_wdata);
            end
            if (proc_start) proc_cnt++;
            proc_next = 0;
            if (rst_n) begin
                if (ld_start && (!active || hlt || ended_err)) begin
                    active = 1; hlt = 0; nwr = 0; mq.delete();
                end else if (writing) begin
                    nwr++;
                    if (w == HLT) begin
                        hlt = 1;
                        proc_next = 1;
                    end
                end else if (exp_ready && s_valid) begin
                    mq.push_back(s_data);
                end
            end
            proc_now = proc_next;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_session();
        ld_start = 1'b1;
        idle(1);
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int pct, input bit poke);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        while (!acc && n < 400) begin
            s_valid  = ($urandom_range(99) < pct);
            s_data   = s_valid ? b : 8'($urandom);
            ld_start = poke && ($urandom_range(7) == 0);
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid  = 1'b0;
        ld_start = 1'b0;
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL byte_timeout: byte %0h not accepted within %0d cycles", b, n);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int pct, input bit poke);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], pct, poke);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HLT) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic check_prog(input int mark);
        check("prog_writes", 64'(log_data.size() - mark), 64'd4);
        if (log_data.size() >= mark + 4) begin
            for (int i = 0; i < 4; i++) begin
                check("prog_addr", 64'(log_addr[mark+i]), 64'(i));
                check("prog_data", 64'(log_data[mark+i]), 64'(PROG[i]));
            end
        end
    endtask

    task automatic driver();
        int mark, pc, n;
        rst_n = 1'b0; sel = 1'b0; ld_start = 1'b0; s_valid = 1'b0; s_data = 8'h0;
        idle(3);
        @(negedge clk);
        check("reset_word_count", 64'(word_count), 64'd0);
        check("reset_s_ready", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Reference program, continuous stream
        mark = log_data.size(); pc = proc_cnt;
        start_session();
        for (int i = 0; i < 4; i++) send_word(PROG[i], 100, 0);
        idle(3);
        check_prog(mark);
        check("t1_done", 64'(load_done), 64'd1);
        check("t1_proc_pulses", 64'(proc_cnt - pc), 64'd1);
        check("t1_word_count", 64'(word_count), 64'd4);

        // Restart from DONE, gappy stream with stray ld_start pulses
        mark = log_data.size(); pc = proc_cnt;
        start_session();
        check("t2_done_cleared", 64'(load_done), 64'd0);
        for (int i = 0; i < 4; i++) send_word(PROG[i], 50, 1);
        idle(3);
        check_prog(mark);
        check("t2_proc_pulses", 64'(proc_cnt - pc), 64'd1);
        check("t2_word_count", 64'(word_count), 64'd4);

        // Reset after two bytes of the first word
        start_session();
        send_byte(8'h28, 70, 0);
        send_byte(8'h01, 70, 0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        mark = log_data.size();
        start_session();
        for (int i = 0; i < 4; i++) send_word(PROG[i], 80, 0);
        idle(3);
        check_prog(mark);

        // Reset landing in the write cycle
        start_session();
        send_word(rand_word(), 100, 0);
        mark = log_data.size();
        rst_n = 1'b0;
        #1;
        check("reset_in_write_we", 64'(mem_we), 64'd0);
        idle(1);
        rst_n = 1'b1;
        idle(2);
        check("reset_in_write_nolog", 64'(log_data.size() - mark), 64'd0);

        // Random programs of 1..6 words ending in the halt word
        repeat (6) begin
            n = $urandom_range(1, 6);
            pc = proc_cnt;
            start_session();
            for (int k = 0; k < n - 1; k++) send_word(rand_word(), $urandom_range(30, 100), $urandom_range(1));
            send_word(HLT, $urandom_range(30, 100), 0);
            idle(3);
            check("rand_done", 64'(load_done), 64'd1);
            check("rand_word_count", 64'(word_count), 64'(n));
            check("rand_proc_pulses", 64'(proc_cnt - pc), 64'd1);
        end

        // Four-word memory: overflow without halt, then a session from ERROR
        rst_n = 1'b0;
        sel = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        mark = log_data.size(); pc = proc_cnt;
        start_session();
        for (int k = 0; k < 4; k++) send_word(rand_word(), 70, 0);
        idle(4);
        check("ovf_err", 64'(load_err), 64'd1);
        check("ovf_writes", 64'(log_data.size() - mark), 64'd4);
        check("ovf_no_proc", 64'(proc_cnt - pc), 64'd0);
        check("ovf_word_count", 64'(word_count), 64'd4);
        mark = log_data.size();
        start_session();
        check("ovf_err_cleared", 64'(load_err), 64'd0);
        for (int i = 0; i < 4; i++) send_word(PROG[i], 60, 0);
        idle(3);
        check_prog(mark);
        check("small_done", 64'(load_done), 64'd1);
    endtask

    initial begin
        tests = 0; fails = 0; proc_cnt = 0;
        active = 0; hlt = 0; nwr = 0; last_addr = 0; last_data = 0; proc_now = 0;
        fork
            monitor();
            driver();
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
